time_capture_unit: RTL

- Multi-channel timestamp unit with a prescaled, free-running BITS-wide time base.
- Each of CHANNELS asynchronous event inputs is synchronised and edge-detected. On a detected edge the current time is latched into that channel's capture register.
- A CPU-side read port with channel select returns either a capture value or the live counter. A read clears the channel's flags.
- Sits on the peripheral bus next to the timers. Used for pulse timing and event timestamping.

---
 rtl/time_capture_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/time_capture_unit.sv
// time_capture_unit: prescaled free-running time base with
// per-channel synchronised edge capture and a CPU read port.
//
// Ports:
//   clk, nreset   clock, synchronous active-low reset
//   enable        time base runs when 1, holds when 0
//   prescale      tick every prescale+1 clk cycles
//   capture_in    asynchronous event inputs, one per channel
//   edge_sel      per-channel 0=rising 1=falling (optional)
//   nrd, addr     active-low read strobe and read select
//   value         registered read data
//   valid_out     registered: selected capture was fresh
//   pending       per-channel capture not yet read
//   overrun       per-channel edge lost while pending
//
// Optional feature macro: TIME_CAPTURE_EDGE_SELECT_EN
// (adds edge_sel; without it only rising edges capture).
module time_capture_unit #(
  parameter int BITS           = 32,
  parameter int CHANNELS       = 4,
  parameter int SEL_BITS       = 3,
  parameter int PRESCALER_BITS = 8
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      enable,
  input  logic [PRESCALER_BITS-1:0] prescale,
  input  logic [CHANNELS-1:0]       capture_in,
`ifdef TIME_CAPTURE_EDGE_SELECT_EN
  input  logic [CHANNELS-1:0]       edge_sel,
`endif
  input  logic                      nrd,
  input  logic [SEL_BITS-1:0]       addr,
  output logic [BITS-1:0]           value,
  output logic                      valid_out,
  output logic [CHANNELS-1:0]       pending,
  output logic [CHANNELS-1:0]       overrun
);

  localparam logic [SEL_BITS-1:0] CH_LIM =
    SEL_BITS'(CHANNELS);

  logic [PRESCALER_BITS-1:0] div_q;
  logic [BITS-1:0]           cnt_q;
  logic                      tick;

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] hist_q;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] edge_det;

  logic [BITS-1:0]     cap_q [CHANNELS];
  logic [CHANNELS-1:0] rd_clr;
  logic                rd_live;
  logic [BITS-1:0]     rd_cap;
  logic                rd_pend;

  // Time base
  // Equality compare only: a divider already past a
  // newly lowered prescale runs on to all-ones, wraps,
  // and then matches.
  assign tick = enable && (div_q == prescale);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      div_q <= '0;
    end else if (enable) begin
      if (tick) div_q <= '0;
      else      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Synchroniser and edge detect
  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= capture_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~hist_q;

`ifdef TIME_CAPTURE_EDGE_SELECT_EN
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] esel_q;

  // Registered so a select change applies from the
  // following cycle, never mid-compare.
  always_ff @(posedge clk) begin
    if (!nreset) esel_q <= '0;
    else         esel_q <= edge_sel;
  end

  assign fall     = ~sync2_q & hist_q;
  assign edge_det = (rise & ~esel_q) |
                    (fall &  esel_q);
`else
  assign edge_det = rise;
`endif

  // Read decode
  assign rd_live = addr >= CH_LIM;

  always_comb begin
    rd_clr  = '0;
    rd_cap  = '0;
    rd_pend = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (addr == SEL_BITS'(i)) begin
        rd_cap  = cap_q[i];
        rd_pend = pending[i];
        rd_clr[i] = ~nrd;
      end
    end
  end

  // Capture registers and flags
  // Keep-first while pending, except when the read that
  // clears the channel lands in the same cycle: then the
  // new edge reloads and stays pending.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cap_q[i] <= '0;
      end
      pending <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (edge_det[i] &&
            (!pending[i] || rd_clr[i])) begin
          cap_q[i] <= cnt_q;
        end

        if (edge_det[i])     pending[i] <= 1'b1;
        else if (rd_clr[i])  pending[i] <= 1'b0;

        if (rd_clr[i])       overrun[i] <= 1'b0;
        else if (edge_det[i] && pending[i])
                             overrun[i] <= 1'b1;
      end
    end
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (!nreset) begin
      value     <= '0;
      valid_out <= 1'b0;
    end else if (!nrd) begin
      unique case (1'b1)
        rd_live: begin
          value     <= cnt_q;
          valid_out <= 1'b1;
        end
        default: begin
          value     <= rd_cap;
          valid_out <= rd_pend;
        end
      endcase
    end
  end

endmodule
